// File: rtl/gcm_aes_frame_sequencer_if.sv
// Block-transfer and GHASH control bundle for the GCM-AES frame sequencer.
// The master side drives frame requests; the slave side is the sequencer.
interface gcm_aes_frame_sequencer_if #(
    parameter int NB_LEN = 8,
    parameter int NB_SEL = 2
);
    logic              i_valid;
    logic              i_start;
    logic [NB_LEN-1:0] i_aad_blocks;
    logic [NB_LEN-1:0] i_data_blocks;
    logic              i_block_valid;
    logic              o_block_ready;
    logic              o_sop;
    logic [NB_SEL-1:0] o_sel_ghash_in;
    logic              o_ghash_valid;
    logic              o_ctr_inc;
    logic              o_tag_valid;
    logic              o_busy;

    modport master (
        output i_valid, i_start, i_aad_blocks, i_data_blocks, i_block_valid,
        input  o_block_ready, o_sop, o_sel_ghash_in, o_ghash_valid,
        input  o_ctr_inc, o_tag_valid, o_busy
    );

    modport slave (
        input  i_valid, i_start, i_aad_blocks, i_data_blocks, i_block_valid,
        output o_block_ready, o_sop, o_sel_ghash_in, o_ghash_valid,
        output o_ctr_inc, o_tag_valid, o_busy
    );
endinterface

// File: rtl/gcm_aes_frame_sequencer.sv
// Frame-level GCM-AES tag path sequencer: paces AAD, DATA and LENGTH
// GHASH phases, then waits out the GHASH pipeline before flagging the tag.
module gcm_aes_frame_sequencer #(
    parameter int NB_LEN        = 8,
    parameter int NB_SEL        = 2,
    parameter int GHASH_LATENCY = 3
) (
    input logic                      i_clock,
    input logic                      i_reset_n,
    gcm_aes_frame_sequencer_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_AAD   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_LEN   = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;

    localparam logic [NB_SEL-1:0] SEL_AAD  = NB_SEL'(0);
    localparam logic [NB_SEL-1:0] SEL_DATA = NB_SEL'(1);
    localparam logic [NB_SEL-1:0] SEL_LEN  = NB_SEL'(2);

    localparam logic [NB_LEN-1:0] ONE      = NB_LEN'(1);
    localparam logic [3:0]        LAT_LAST = 4'(GHASH_LATENCY - 1);

    logic [2:0]        state_q, state_d;
    logic [NB_LEN-1:0] aad_q, aad_d;
    logic [NB_LEN-1:0] data_q, data_d;
    logic [NB_LEN-1:0] cnt_q, cnt_d;
    logic [3:0]        lat_q, lat_d;
    logic              tag_q, tag_d;

    logic run;
    logic in_idle;
    logic in_xfer;
    logic hs;
    logic start_acc;

    // Strobes are qualified by reset so nothing fires while reset is held.
    always_comb begin
        run       = bus.i_valid & i_reset_n;
        in_idle   = (state_q == S_IDLE);
        in_xfer   = (state_q == S_AAD) || (state_q == S_DATA);
        hs        = run & bus.i_block_valid & in_xfer;
        start_acc = run & bus.i_start & in_idle;
    end

    // Zero-latency handshake and GHASH control outputs.
    always_comb begin
        bus.o_block_ready = in_xfer;
        bus.o_sop         = start_acc;
        bus.o_ghash_valid = hs | (run & (state_q == S_LEN));
        bus.o_ctr_inc     = hs & (state_q == S_DATA);
        bus.o_tag_valid   = tag_q;
        bus.o_busy        = ~in_idle;
        case (state_q)
            S_AAD:   bus.o_sel_ghash_in = SEL_AAD;
            S_DATA:  bus.o_sel_ghash_in = SEL_DATA;
            S_LEN:   bus.o_sel_ghash_in = SEL_LEN;
            default: bus.o_sel_ghash_in = SEL_AAD;
        endcase
    end

    // Phase sequencing; everything holds while i_valid is low.
    always_comb begin
        state_d = state_q;
        aad_d   = aad_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        tag_d   = tag_q;
        if (bus.i_valid) begin
            tag_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.i_start) begin
                        aad_d  = bus.i_aad_blocks;
                        data_d = bus.i_data_blocks;
                        cnt_d  = '0;
                        if (bus.i_aad_blocks != '0)
                            state_d = S_AAD;
                        else if (bus.i_data_blocks != '0)
                            state_d = S_DATA;
                        else
                            state_d = S_LEN;
                    end
                end
                S_AAD: begin
                    if (bus.i_block_valid) begin
                        if (cnt_q == aad_q - ONE) begin
                            cnt_d   = '0;
                            state_d = (data_q != '0) ? S_DATA : S_LEN;
                        end else begin
                            cnt_d = cnt_q + ONE;
                        end
                    end
                end
                S_DATA: begin
                    if (bus.i_block_valid) begin
                        if (cnt_q == data_q - ONE) begin
                            cnt_d   = '0;
                            state_d = S_LEN;
                        end else begin
                            cnt_d = cnt_q + ONE;
                        end
                    end
                end
                S_LEN: begin
                    lat_d   = '0;
                    state_d = S_FLUSH;
                end
                S_FLUSH: begin
                    if (lat_q == LAT_LAST) begin
                        tag_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        lat_d = lat_q + 4'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            aad_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            lat_q   <= '0;
            tag_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            aad_q   <= aad_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            tag_q   <= tag_d;
        end
    end
endmodule

// File: tb/tb_gcm_aes_frame_sequencer.sv
// Randomized bench for gcm_aes_frame_sequencer: a queue-based model of the
// expected GHASH block stream is compared against the DUT every cycle.
module tb_gcm_aes_frame_sequencer;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gcm_aes_frame_sequencer_if #(.NB_LEN(8), .NB_SEL(2)) bus ();

    gcm_aes_frame_sequencer #(
        .NB_LEN(8), .NB_SEL(2), .GHASH_LATENCY(LAT)
    ) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    int checks = 0;
    int passes = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        else
            passes++;
    endfunction

    // Model: queue of pending GHASH selects (0 AAD, 1 DATA, 2 LEN),
    // then a count of i_valid cycles left for the pipeline drain.
    int q[$];
    int flush_left = 0;
    bit mtag = 1'b0;

    function automatic bit m_busy();
        return (q.size() != 0) || (flush_left != 0);
    endfunction
    function automatic bit m_sop();
        return rst_n && bus.i_valid && bus.i_start && !m_busy();
    endfunction
    function automatic bit m_ready();
        return (q.size() != 0) && (q[0] != 2);
    endfunction
    function automatic bit m_gv();
        if (!(rst_n && bus.i_valid) || q.size() == 0) return 1'b0;
        return (q[0] == 2) || bus.i_block_valid;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            flush_left = 0;
            mtag = 1'b0;
        end else if (bus.i_valid) begin
            bit sop_now;
            bit gv_now;
            sop_now = m_sop();
            gv_now  = m_gv();
            mtag = 1'b0;
            if (sop_now) begin
                for (int i = 0; i < int'(bus.i_aad_blocks); i++) q.push_back(0);
                for (int i = 0; i < int'(bus.i_data_blocks); i++) q.push_back(1);
                q.push_back(2);
            end else if (gv_now) begin
                if (q[0] == 2) flush_left = LAT;
                void'(q.pop_front());
            end else if (q.size() == 0 && flush_left > 0) begin
                flush_left--;
                if (flush_left == 0) mtag = 1'b1;
            end
        end
    end

    // Monitor counters for pinned scenario expectations.
    bit mon_en = 1'b0;
    int cyc = 0;
    int sel_log[16];
    int nsel, n_ctr, n_ready, n_hs, n_tag, n_sop, n_soptag;
    int len_cyc, tag_cyc, sop_cyc;

    task automatic clr();
        nsel = 0; n_ctr = 0; n_ready = 0; n_hs = 0; n_tag = 0;
        n_sop = 0; n_soptag = 0; len_cyc = 0; tag_cyc = 0; sop_cyc = 0;
    endtask

    // Single compare process plus event logging.
    always @(negedge clk) begin
        if (mon_en) begin
            bit gv;
            gv = m_gv();
            chk("busy", bus.o_busy, m_busy());
            chk("tag_valid", bus.o_tag_valid, mtag);
            chk("sop", bus.o_sop, m_sop());
            chk("block_ready", bus.o_block_ready, m_ready());
            chk("ghash_valid", bus.o_ghash_valid, gv);
            chk("ctr_inc", bus.o_ctr_inc, gv && q[0] == 1);
            if (gv) chk("sel", bus.o_sel_ghash_in, q[0]);
            cyc++;
            if (bus.o_ghash_valid) begin
                if (nsel < 16) sel_log[nsel] = int'(bus.o_sel_ghash_in);
                nsel++;
                if (bus.o_sel_ghash_in == 2'd2) len_cyc = cyc;
            end
            if (bus.o_ctr_inc) n_ctr++;
            if (bus.o_block_ready) n_ready++;
            if (bus.o_block_ready && bus.i_valid && bus.i_block_valid && rst_n) n_hs++;
            if (bus.o_tag_valid && bus.i_valid) begin
                n_tag++;
                tag_cyc = cyc;
                if (bus.o_sop) n_soptag++;
            end
            if (bus.o_sop) begin
                if (n_sop == 0) sop_cyc = cyc;
                n_sop++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(int a, int d);
        bus.i_aad_blocks  = 8'(a);
        bus.i_data_blocks = 8'(d);
        bus.i_valid       = 1'b1;
        bus.i_start       = 1'b1;
        tick();
        bus.i_start = 1'b0;
    endtask

    // mode 0: all valid; mode 1: random valid/block_valid with stray starts.
    task automatic run_tags(int n, int budget, int mode, string name);
        int k;
        k = 0;
        while (n_tag < n && k < budget) begin
            if (mode == 0) begin
                bus.i_valid       = 1'b1;
                bus.i_block_valid = 1'b1;
            end else begin
                bus.i_valid       = ($urandom_range(0, 3) != 0);
                bus.i_block_valid = 1'($urandom_range(0, 1));
                bus.i_start       = (n_hs < 4) && ($urandom_range(0, 3) == 0);
            end
            tick();
            bus.i_start = 1'b0;
            k++;
        end
        if (k >= budget) chk({name, "_timeout"}, 0, 1);
    endtask

    int exp_sel[6] = '{0, 0, 1, 1, 1, 2};

    initial begin
        int k;
        bus.i_valid       = 1'b1;
        bus.i_start       = 1'b1;
        bus.i_aad_blocks  = 8'd3;
        bus.i_data_blocks = 8'd3;
        bus.i_block_valid = 1'b1;
        clr();
        tick();
        mon_en = 1'b1;
        tick();
        tick();
        chk("start_in_reset_ignored", n_sop, 0);
        bus.i_start = 1'b0;
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_busy", bus.o_busy, 0);

        // AAD 2, DATA 3, continuous valid
        clr();
        start_frame(2, 3);
        run_tags(1, 40, 0, "f23");
        chk("f23_nsel", nsel, 6);
        for (int i = 0; i < 6; i++) chk("f23_sel_seq", sel_log[i], exp_sel[i]);
        chk("f23_ctr", n_ctr, 3);
        chk("f23_len_to_tag", tag_cyc - len_cyc, LAT + 1);
        tick();

        // minimum frame
        clr();
        start_frame(0, 0);
        run_tags(1, 20, 0, "f00");
        chk("f00_nsel", nsel, 1);
        chk("f00_sop_to_tag", tag_cyc - sop_cyc, LAT + 2);
        chk("f00_ready", n_ready, 0);
        tick();

        // AAD 1, DATA 4, random pacing with stray starts
        clr();
        start_frame(1, 4);
        run_tags(1, 400, 1, "f14");
        chk("f14_hs", n_hs, 5);
        chk("f14_ctr", n_ctr, 4);
        chk("f14_tag", n_tag, 1);
        chk("f14_sop", n_sop, 1);
        bus.i_valid = 1'b1;
        tick();

        // reset during DATA after 2 of 4 blocks
        clr();
        bus.i_block_valid = 1'b1;
        start_frame(0, 4);
        k = 0;
        while (n_ctr < 2 && k < 20) begin
            tick();
            k++;
        end
        if (k >= 20) chk("rst_wait_timeout", 0, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_busy", bus.o_busy, 0);
        bus.i_block_valid = 1'b0;
        repeat (8) tick();
        chk("rst_no_tag", n_tag, 0);
        chk("rst_ctr", n_ctr, 2);
        clr();
        start_frame(0, 1);
        run_tags(1, 20, 0, "f01");
        chk("f01_ctr", n_ctr, 1);
        chk("f01_tag", n_tag, 1);
        tick();

        // back-to-back with start held high
        clr();
        bus.i_aad_blocks  = 8'd1;
        bus.i_data_blocks = 8'd1;
        bus.i_valid       = 1'b1;
        bus.i_block_valid = 1'b1;
        bus.i_start       = 1'b1;
        k = 0;
        while (n_sop < 2 && k < 40) begin
            tick();
            k++;
        end
        if (k >= 40) chk("b2b_timeout", 0, 1);
        bus.i_start = 1'b0;
        chk("b2b_sop_with_tag", n_soptag, 1);
        run_tags(2, 40, 0, "b2b");
        chk("b2b_tags", n_tag, 2);
        tick();

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
